// File: rtl/pulse_seq_ctrl_if.sv
// Config/control bus between a host and pulse_seq_ctrl.
// Handshake: start is a one-cycle request. It is taken only in IDLE, has no ready, and is dropped when not taken.
interface pulse_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic [AW-1:0]    cfg_last;
    logic             cfg_loop;
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic [AW-1:0]    slot;
    logic             slot_pulse;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_last, cfg_loop, start, abort,
        input  busy, done, err, slot, slot_pulse
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_last, cfg_loop, start, abort,
        output busy, done, err, slot, slot_pulse
    );
endinterface

// File: rtl/pulse_seq_ctrl.sv
// Steps one load/pulse counter through a table of load values.
// For each slot it holds the counter in reset, applies the load value and waits for the terminal pulse.
module pulse_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pulse_seq_ctrl_if.slave  bus,
    output logic             cnt_rst_o,
    output logic [WIDTH-1:0] cnt_load_o,
    input  logic             cnt_pulse_i,
    output logic [1:0]       state_o
);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int ACW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [ACW-1:0] ARM_LAST = ACW'(RST_CYC - 1);
    localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] tbl_q [DEPTH];
    logic [AW-1:0]    last_q;
    logic             loop_q;
    logic [AW-1:0]    slot_q;
    logic [AW-1:0]    slot_d;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             slot_pulse_q;
    logic             cnt_rst_q;
    logic [WIDTH-1:0] cnt_load_q;
    logic [ACW-1:0]   arm_q;
    logic [WDW-1:0]   wdog_q;

    always_comb begin
        slot_d = (slot_q == last_q) ? '0 : slot_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            last_q       <= '0;
            loop_q       <= 1'b0;
            slot_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            slot_pulse_q <= 1'b0;
            cnt_rst_q    <= 1'b1;
            cnt_load_q   <= '0;
            arm_q        <= '0;
            wdog_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            done_q       <= 1'b0;
            slot_pulse_q <= 1'b0;
            // The table is frozen for the whole sequence so cnt_load cannot change under the counter.
            if (bus.cfg_we && !busy_q) begin
                tbl_q[bus.cfg_addr] <= bus.cfg_data;
            end
            if (bus.abort) begin
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
                cnt_rst_q <= 1'b1;
                slot_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            last_q     <= bus.cfg_last;
                            loop_q     <= bus.cfg_loop;
                            err_q      <= 1'b0;
                            slot_q     <= '0;
                            state_q    <= S_ARM;
                            busy_q     <= 1'b1;
                            cnt_load_q <= tbl_q[AW'(0)];
                            cnt_rst_q  <= 1'b1;
                            arm_q      <= '0;
                        end
                    end
                    S_ARM: begin
                        if (arm_q == ARM_LAST) begin
                            state_q   <= S_RUN;
                            cnt_rst_q <= 1'b0;
                            wdog_q    <= '0;
                        end else begin
                            arm_q <= arm_q + 1'b1;
                        end
                    end
                    S_RUN: begin
                        // A pulse in the last watchdog cycle still counts as a completed slot.
                        if (cnt_pulse_i) begin
                            slot_pulse_q <= 1'b1;
                            cnt_rst_q    <= 1'b1;
                            if ((slot_q != last_q) || loop_q) begin
                                slot_q     <= slot_d;
                                cnt_load_q <= tbl_q[slot_d];
                                arm_q      <= '0;
                                state_q    <= S_ARM;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else if (wdog_q == WD_MAX) begin
                            err_q     <= 1'b1;
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                            cnt_rst_q <= 1'b1;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.slot       = slot_q;
    assign bus.slot_pulse = slot_pulse_q;
    assign cnt_rst_o      = cnt_rst_q;
    assign cnt_load_o     = cnt_load_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Bench for pulse_seq_ctrl: a behavioural counter drives cnt_pulse; expectations come from the load table.
module tb_pulse_seq_ctrl;
    localparam int WIDTH   = 8;
    localparam int AW      = 2;
    localparam int DEPTH   = 4;
    localparam int RST_CYC = 2;
    localparam int TIMEOUT = 15;
    localparam logic [14:0] RST_STATUS = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h00};

    logic             clk;
    logic             rst;
    logic             cnt_rst;
    logic [WIDTH-1:0] cnt_load;
    logic             cnt_pulse;
    logic [1:0]       state_dbg;

    int               errors = 0;
    int               checks = 0;
    logic [WIDTH-1:0] model_tbl [DEPTH];
    bit               pulse_en = 1'b1;
    int               m_cnt;
    bit               m_fired;

    pulse_seq_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    pulse_seq_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus.slave),
        .cnt_rst_o  (cnt_rst),
        .cnt_load_o (cnt_load),
        .cnt_pulse_i(cnt_pulse),
        .state_o    (state_dbg)
    );

    wire [14:0] status = {bus.busy, bus.done, bus.err, bus.slot, bus.slot_pulse, cnt_rst, cnt_load};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Counter: counts cycles since its reset dropped and pulses once when the count equals load.
    always @(posedge clk) begin
        if (cnt_rst) begin
            m_cnt   <= 0;
            m_fired <= 1'b0;
        end else if (cnt_pulse) begin
            m_fired <= 1'b1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign cnt_pulse = pulse_en && !cnt_rst && !m_fired && (m_cnt == int'(cnt_load));

    // ---------------- drivers ----------------
    task automatic write_tbl(input int addr, input logic [WIDTH-1:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr[AW-1:0];
        bus.cfg_data = data;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        model_tbl[addr] = data;
    endtask

    task automatic do_start(input int last, input bit lp);
        bus.cfg_last = last[AW-1:0];
        bus.cfg_loop = lp;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain busy=%b after %0d cycles, required 0", name, bus.busy, n);
        end
        @(negedge clk);
    endtask

    // Non-loop sequence over slots 0..last; each slot takes RST_CYC arm cycles plus load+1 run cycles.
    task automatic run_seq(input int last, input bit poke, input string name);
        logic [AW+WIDTH-1:0] exp_q[$];
        logic [AW+WIDTH-1:0] exp_v;
        logic [AW+WIDTH-1:0] got_v;
        int   exp_cyc, pulses, dones, done_cyc, late_busy;
        logic prev_rst;
        exp_cyc = 1;
        for (int s = 0; s <= last; s++) begin
            exp_q.push_back({AW'(s), model_tbl[s]});
            exp_cyc += RST_CYC + int'(model_tbl[s]) + 1;
        end
        pulses = 0; dones = 0; done_cyc = 0; late_busy = 0; prev_rst = 1'b1;
        do_start(last, 1'b0);
        for (int cyc = 1; cyc <= exp_cyc + 4; cyc++) begin
            if (bus.busy && !cnt_rst && prev_rst) begin
                got_v = {bus.slot, cnt_load};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra_slot slot/load=%h, required none", name, got_v);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got_v !== exp_v) begin
                        errors++;
                        $display("FAIL %s_slot_load slot/load=%h, required %h", name, got_v, exp_v);
                    end
                end
            end
            if (bus.slot_pulse) pulses++;
            if (bus.done) begin
                dones++;
                done_cyc = cyc;
            end else if (dones > 0 && bus.busy) begin
                late_busy++;
            end
            prev_rst = cnt_rst;
            if (poke && cyc == 3) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = 2'd1;
                bus.cfg_data = 8'd9;
                bus.start    = 1'b1;
            end else if (poke && cyc == 4) begin
                bus.cfg_we = 1'b0;
                bus.start  = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1 || done_cyc !== exp_cyc) begin
            errors++;
            $display("FAIL %s_done count=%0d at cycle %0d, required 1 at cycle %0d", name, dones, done_cyc, exp_cyc);
        end
        checks++;
        if (pulses !== last + 1) begin
            errors++;
            $display("FAIL %s_slot_pulses got=%0d, required %0d", name, pulses, last + 1);
        end
        checks++;
        if (exp_q.size() !== 0 || late_busy !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_tail missing_slots=%0d late_busy=%0d busy=%b, required 0/0/0",
                     name, exp_q.size(), late_busy, bus.busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (status !== RST_STATUS) begin
            errors++;
            $display("FAIL reset_status got=%h, required %h", status, RST_STATUS);
        end
        rst = 1'b0;
        for (int s = 0; s < DEPTH; s++) model_tbl[s] = '0;
        @(negedge clk);
    endtask

    task automatic test_sequence();
        write_tbl(0, 8'd4);
        write_tbl(1, 8'd2);
        write_tbl(2, 8'd7);
        write_tbl(3, 8'd1);
        run_seq(3, 1'b0, "seq4271");
    endtask

    task automatic test_loop_abort();
        int   pulses, wraps, exp_slot;
        logic prev_rst;
        bit   aborted;
        logic [AW+WIDTH-1:0] exp_v;
        pulses = 0; wraps = 0; exp_slot = 0; prev_rst = 1'b1; aborted = 1'b0;
        do_start(3, 1'b1);
        for (int cyc = 0; cyc < 400 && !aborted; cyc++) begin
            if (bus.busy && !cnt_rst && prev_rst) begin
                exp_v = {AW'(exp_slot), model_tbl[exp_slot]};
                checks++;
                if ({bus.slot, cnt_load} !== exp_v) begin
                    errors++;
                    $display("FAIL loop_slot_load slot/load=%h, required %h", {bus.slot, cnt_load}, exp_v);
                end
                exp_slot = (exp_slot == 3) ? 0 : exp_slot + 1;
            end
            if (bus.slot_pulse) begin
                pulses++;
                if (bus.slot == 2'd0) wraps++;
            end
            prev_rst = cnt_rst;
            if (pulses >= 9 && cnt_pulse) begin
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                aborted = 1'b1;
                checks++;
                if ({bus.busy, bus.done, bus.slot_pulse, cnt_rst, bus.slot} !== {3'b000, 1'b1, 2'b00}) begin
                    errors++;
                    $display("FAIL abort_outputs busy/done/slot_pulse/cnt_rst/slot=%b, required 000100",
                             {bus.busy, bus.done, bus.slot_pulse, cnt_rst, bus.slot});
                end
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!aborted || wraps < 2) begin
            errors++;
            $display("FAIL loop_wraps aborted=%0d wraps=%0d, required 1 and >=2", aborted, wraps);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_timeout();
        int run_cyc, n;
        bit saw_done;
        run_cyc = 0; n = 0; saw_done = 1'b0;
        pulse_en = 1'b0;
        do_start(0, 1'b0);
        while (!bus.err && n < 100) begin
            if (bus.busy && !cnt_rst) run_cyc++;
            if (bus.done) saw_done = 1'b1;
            @(negedge clk);
            n++;
        end
        // The watchdog reads 0 in the first RUN cycle, so TIMEOUT+1 RUN cycles pass before err.
        checks++;
        if (bus.err !== 1'b1 || run_cyc !== TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_err err=%b run_cycles=%0d, required 1 and %0d", bus.err, run_cyc, TIMEOUT + 1);
        end
        checks++;
        if (bus.busy !== 1'b0 || cnt_rst !== 1'b1 || bus.done !== 1'b0 || saw_done) begin
            errors++;
            $display("FAIL timeout_idle busy=%b cnt_rst=%b done=%b saw_done=%0d, required 0 1 0 0",
                     bus.busy, cnt_rst, bus.done, saw_done);
        end
        pulse_en = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky err=%b, required 1", bus.err);
        end
        do_start(0, 1'b0);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear err=%b, required 0", bus.err);
        end
        wait_idle("timeout");
    endtask

    task automatic test_timing();
        write_tbl(0, 8'd5);
        do_start(0, 1'b0);
        checks++;
        if ({bus.busy, cnt_rst, bus.slot, cnt_load} !== {1'b1, 1'b1, 2'b00, 8'd5}) begin
            errors++;
            $display("FAIL arm_first busy/cnt_rst/slot/load=%h, required %h",
                     {bus.busy, cnt_rst, bus.slot, cnt_load}, {1'b1, 1'b1, 2'b00, 8'd5});
        end
        @(negedge clk);
        checks++;
        if (cnt_rst !== 1'b1) begin
            errors++;
            $display("FAIL arm_hold cnt_rst=%b, required 1", cnt_rst);
        end
        @(negedge clk);
        checks++;
        if (cnt_rst !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL run_entry cnt_rst=%b busy=%b, required 0 1", cnt_rst, bus.busy);
        end
        wait_idle("timing");
    endtask

    task automatic test_back_to_back();
        write_tbl(0, 8'd4);
        write_tbl(1, 8'd2);
        write_tbl(2, 8'd7);
        write_tbl(3, 8'd1);
        run_seq(3, 1'b1, "busy_poke");
        run_seq(3, 1'b0, "after_poke");
    endtask

    task automatic test_rst_mid();
        int n;
        n = 0;
        do_start(3, 1'b0);
        while (!(bus.busy && !cnt_rst) && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (status !== RST_STATUS) begin
            errors++;
            $display("FAIL rst_mid_status got=%h, required %h", status, RST_STATUS);
        end
        rst = 1'b0;
        for (int s = 0; s < DEPTH; s++) model_tbl[s] = '0;
        @(negedge clk);
        run_seq(3, 1'b0, "cleared_tbl");
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || cnt_rst !== 1'b1) begin
            errors++;
            $display("FAIL abort_start busy=%b cnt_rst=%b, required 0 1", bus.busy, cnt_rst);
        end
    endtask

    task automatic test_random();
        int last;
        for (int it = 0; it < 6; it++) begin
            for (int s = 0; s < DEPTH; s++) write_tbl(s, 8'($urandom_range(0, 9)));
            last = $urandom_range(0, 3);
            run_seq(last, 1'b0, "random");
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.cfg_last = '0;
        bus.cfg_loop = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        test_reset();
        test_sequence();
        test_loop_abort();
        test_timeout();
        test_timing();
        test_back_to_back();
        test_random();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
